// File: rtl/fcmp_sched_if.sv
// Request, comparator and response signals of the shared Fleq compare scheduler.
// slave: scheduler side; master: requesters, comparator and response consumer.
interface fcmp_sched_if;
   localparam int unsigned DATA_W = 32;

   logic              req0_valid;
   logic              req1_valid;
   logic [DATA_W-1:0] req0_a;
   logic [DATA_W-1:0] req0_b;
   logic [DATA_W-1:0] req1_a;
   logic [DATA_W-1:0] req1_b;
   logic              req0_ready;
   logic              req1_ready;

   logic              cmp_en;
   logic [DATA_W-1:0] cmp_a;
   logic [DATA_W-1:0] cmp_b;
   logic [DATA_W-1:0] cmp_result;

   logic              rsp_valid;
   logic              rsp_id;
   logic              rsp_leq;
   logic              rsp_nan;
   logic              rsp_ready;

   modport slave (
      input  req0_valid, req1_valid, req0_a, req0_b, req1_a, req1_b,
      output req0_ready, req1_ready,
      output cmp_en, cmp_a, cmp_b,
      input  cmp_result,
      output rsp_valid, rsp_id, rsp_leq, rsp_nan,
      input  rsp_ready
   );

   modport master (
      output req0_valid, req1_valid, req0_a, req0_b, req1_a, req1_b,
      input  req0_ready, req1_ready,
      input  cmp_en, cmp_a, cmp_b,
      output cmp_result,
      input  rsp_valid, rsp_id, rsp_leq, rsp_nan,
      output rsp_ready
   );
endinterface

// File: rtl/fcmp_sched.sv
// fcmp_sched: round-robin scheduler sharing one Fleq (a <= b) comparator
// between two requesters. Grant -> ISSUE for CMP_LAT cycles -> RESP until
// the consumer accepts.
// Optional feature macro: FCMP_NAN_CHECK_EN (NaN operands bypass the
// comparator and return rsp_nan = 1, rsp_leq = 0 one cycle after grant).
module fcmp_sched #(
   parameter int unsigned CMP_LAT = 1
) (
   input logic         clk,
   input logic         rst,
   fcmp_sched_if.slave bus
);
   localparam int unsigned DATA_W = 32;
   localparam int unsigned CNT_W  = 4;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      RESP  = 2'd2
   } state_t;

   state_t            state;
   logic              ptr;
   logic [CNT_W-1:0]  cnt;
   logic              cmp_en_q;
   logic [DATA_W-1:0] cmp_a_q;
   logic [DATA_W-1:0] cmp_b_q;
   logic              rsp_valid_q;
   logic              rsp_id_q;
   logic              rsp_leq_q;

   logic              grant_c;
   logic              gid_c;
   logic [DATA_W-1:0] sel_a_c;
   logic [DATA_W-1:0] sel_b_c;
   logic              op_nan_c;

   // Round-robin grant: only in IDLE and never while reset is asserted
   always_comb begin
      grant_c = 1'b0;
      gid_c   = 1'b0;
      if (state == IDLE && !rst) begin
         if (bus.req0_valid && bus.req1_valid) begin
            grant_c = 1'b1;
            gid_c   = ptr;
         end else if (bus.req0_valid) begin
            grant_c = 1'b1;
         end else if (bus.req1_valid) begin
            grant_c = 1'b1;
            gid_c   = 1'b1;
         end
      end
   end

   assign sel_a_c        = gid_c ? bus.req1_a : bus.req0_a;
   assign sel_b_c        = gid_c ? bus.req1_b : bus.req0_b;
   assign bus.req0_ready = grant_c & ~gid_c;
   assign bus.req1_ready = grant_c & gid_c;

`ifdef FCMP_NAN_CHECK_EN
   logic rsp_nan_q;

   function automatic logic is_nan(input logic [DATA_W-1:0] x);
      return (x[30:23] == 8'hFF) && (x[22:0] != 23'h0);
   endfunction

   assign op_nan_c    = is_nan(sel_a_c) | is_nan(sel_b_c);
   assign bus.rsp_nan = rsp_nan_q;

   // NaN flag is decided at grant and held through RESP
   always_ff @(posedge clk) begin
      if (rst) begin
         rsp_nan_q <= 1'b0;
      end else if (grant_c) begin
         rsp_nan_q <= op_nan_c;
      end
   end
`else
   assign op_nan_c    = 1'b0;
   assign bus.rsp_nan = 1'b0;
`endif

   // Scheduler FSM with registered comparator drive and response outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         ptr         <= 1'b0;
         cnt         <= '0;
         cmp_en_q    <= 1'b0;
         cmp_a_q     <= '0;
         cmp_b_q     <= '0;
         rsp_valid_q <= 1'b0;
         rsp_id_q    <= 1'b0;
         rsp_leq_q   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (grant_c) begin
                  cmp_a_q  <= sel_a_c;
                  cmp_b_q  <= sel_b_c;
                  rsp_id_q <= gid_c;
                  ptr      <= ~gid_c;
                  cnt      <= '0;
                  if (op_nan_c) begin
                     state       <= RESP;
                     rsp_valid_q <= 1'b1;
                     rsp_leq_q   <= 1'b0;
                  end else begin
                     state    <= ISSUE;
                     cmp_en_q <= 1'b1;
                  end
               end
            end
            ISSUE: begin
               cnt <= cnt + CNT_W'(1);
               if (cnt == CNT_W'(CMP_LAT - 1)) begin
                  rsp_leq_q   <= |bus.cmp_result;
                  rsp_valid_q <= 1'b1;
                  cmp_en_q    <= 1'b0;
                  state       <= RESP;
               end
            end
            RESP: begin
               if (bus.rsp_ready) begin
                  rsp_valid_q <= 1'b0;
                  state       <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.cmp_en    = cmp_en_q;
   assign bus.cmp_a     = cmp_a_q;
   assign bus.cmp_b     = cmp_b_q;
   assign bus.rsp_valid = rsp_valid_q;
   assign bus.rsp_id    = rsp_id_q;
   assign bus.rsp_leq   = rsp_leq_q;
endmodule

// File: tb/tb_fcmp_sched.sv
// Bench for fcmp_sched: two instances (CMP_LAT = 1 and CMP_LAT = 3) share one
// stimulus set; sel picks which instance is exercised and observed. A
// transaction-level model predicts grant order, latency and result.
module tb_fcmp_sched;
   localparam int unsigned LAT = 3;
`ifdef FCMP_NAN_CHECK_EN
   localparam bit NAN_EN = 1'b1;
`else
   localparam bit NAN_EN = 1'b0;
`endif

   logic        clk;
   logic        rst;
   logic        sel;
   logic        v0, v1, rdy;
   logic [31:0] a0, b0, a1, b1;
   logic        mptr [2];
   int          n_pass, n_tot;

   fcmp_sched_if if_l1 ();
   fcmp_sched_if if_l3 ();

   fcmp_sched #(.CMP_LAT(1))   u_dut1 (.clk(clk), .rst(rst), .bus(if_l1.slave));
   fcmp_sched #(.CMP_LAT(LAT)) u_dut3 (.clk(clk), .rst(rst), .bus(if_l3.slave));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic is_nan(input logic [31:0] x);
      return (x[30:23] == 8'hFF) && (x[22:0] != 23'h0);
   endfunction

   // IEEE-754 ordering on sign/magnitude: unordered -> false, +0 == -0
   function automatic logic fleq(input logic [31:0] x, input logic [31:0] y);
      if (is_nan(x) || is_nan(y)) return 1'b0;
      if (x[30:0] == 31'h0 && y[30:0] == 31'h0) return 1'b1;
      if (x[31] != y[31]) return x[31];
      if (!x[31]) return x[30:0] <= y[30:0];
      return x[30:0] >= y[30:0];
   endfunction

   // Comparator model: nonzero (not always bit 0) when a <= b
   function automatic logic [31:0] ref_cmp(input logic en, input logic [31:0] x, input logic [31:0] y);
      return (en && fleq(x, y)) ? (32'h1 << x[4:0]) : 32'h0;
   endfunction

   assign if_l1.cmp_result = ref_cmp(if_l1.cmp_en, if_l1.cmp_a, if_l1.cmp_b);
   assign if_l3.cmp_result = ref_cmp(if_l3.cmp_en, if_l3.cmp_a, if_l3.cmp_b);

   assign if_l1.req0_valid = v0 & ~sel;
   assign if_l1.req1_valid = v1 & ~sel;
   assign if_l1.rsp_ready  = rdy & ~sel;
   assign if_l3.req0_valid = v0 & sel;
   assign if_l3.req1_valid = v1 & sel;
   assign if_l3.rsp_ready  = rdy & sel;
   assign if_l1.req0_a = a0;
   assign if_l1.req0_b = b0;
   assign if_l1.req1_a = a1;
   assign if_l1.req1_b = b1;
   assign if_l3.req0_a = a0;
   assign if_l3.req0_b = b0;
   assign if_l3.req1_a = a1;
   assign if_l3.req1_b = b1;

   logic        o_r0, o_r1, o_en, o_rv, o_id, o_leq, o_nan;
   logic [31:0] o_ca, o_cb;
   assign o_r0  = sel ? if_l3.req0_ready : if_l1.req0_ready;
   assign o_r1  = sel ? if_l3.req1_ready : if_l1.req1_ready;
   assign o_en  = sel ? if_l3.cmp_en     : if_l1.cmp_en;
   assign o_ca  = sel ? if_l3.cmp_a      : if_l1.cmp_a;
   assign o_cb  = sel ? if_l3.cmp_b      : if_l1.cmp_b;
   assign o_rv  = sel ? if_l3.rsp_valid  : if_l1.rsp_valid;
   assign o_id  = sel ? if_l3.rsp_id     : if_l1.rsp_id;
   assign o_leq = sel ? if_l3.rsp_leq    : if_l1.rsp_leq;
   assign o_nan = sel ? if_l3.rsp_nan    : if_l1.rsp_nan;

   // One request/response transaction on instance s, checked against the model
   task automatic run_txn(input logic s, input logic rv0, input logic rv1,
                          input logic [31:0] ia0, input logic [31:0] ib0,
                          input logic [31:0] ia1, input logic [31:0] ib1,
                          input int unsigned stall, input logic kl, input logic gl);
      logic        exp_id, exp_nan, exp_leq, bad_rdy, bad_ops, bad_hold;
      logic [31:0] ea, eb;
      int unsigned lat, exp_lat, n, en_cnt;
      @(negedge clk);
      #1;
      n_tot++;
      if (o_rv !== 1'b0) $display("FAIL rsp_release: rsp_valid=%b required 0", o_rv);
      else n_pass++;
      sel = s;
      rdy = 1'($urandom_range(0, 1));
      a0 = ia0; b0 = ib0; a1 = ia1; b1 = ib1;
      v0 = rv0; v1 = rv1;
      exp_id  = (rv0 && rv1) ? mptr[s] : rv1;
      mptr[s] = ~exp_id;
      ea      = exp_id ? ia1 : ia0;
      eb      = exp_id ? ib1 : ib0;
      exp_nan = NAN_EN && (is_nan(ea) || is_nan(eb));
      exp_leq = !exp_nan && fleq(ea, eb);
      lat     = s ? LAT : 1;
      exp_lat = exp_nan ? 1 : lat + 1;
      #1;
      n_tot++;
      if ({o_r1, o_r0} !== (exp_id ? 2'b10 : 2'b01))
         $display("FAIL grant: ready={r1,r0}=%b%b required id %0d", o_r1, o_r0, exp_id);
      else n_pass++;

      n = 0; en_cnt = 0; bad_rdy = 1'b0; bad_ops = 1'b0;
      do begin
         @(negedge clk);
         n++;
         if (exp_id) v1 = 1'b0; else v0 = 1'b0;
         if (!kl) begin v0 = 1'b0; v1 = 1'b0; end
         if (gl && n == 1) begin
            if (exp_id) v0 = 1'b1; else v1 = 1'b1;
         end
         #1;
         if (o_r0 || o_r1) bad_rdy = 1'b1;
         if (o_en) begin
            en_cnt++;
            if (o_ca !== ea || o_cb !== eb) bad_ops = 1'b1;
         end
         if (!o_rv) rdy = 1'($urandom_range(0, 1));
      end while (!o_rv && n < lat + 8);
      if (!kl) begin v0 = 1'b0; v1 = 1'b0; end
      rdy = 1'b0;

      n_tot++;
      if (n !== exp_lat) $display("FAIL latency: rsp_valid after %0d cycles required %0d", n, exp_lat);
      else n_pass++;
      n_tot++;
      if (en_cnt !== (exp_nan ? 0 : lat))
         $display("FAIL cmp_en_cycles: %0d required %0d", en_cnt, exp_nan ? 0 : lat);
      else n_pass++;
      n_tot++;
      if (bad_ops) $display("FAIL cmp_ops: operands differ from granted a=%h b=%h", ea, eb);
      else n_pass++;
      n_tot++;
      if (bad_rdy) $display("FAIL ready_busy: ready seen while busy, required 0");
      else n_pass++;
      n_tot++;
      if ({o_id, o_leq, o_nan} !== {exp_id, exp_leq, exp_nan})
         $display("FAIL rsp_fields: id/leq/nan=%b%b%b required %b%b%b",
                  o_id, o_leq, o_nan, exp_id, exp_leq, exp_nan);
      else n_pass++;
      n_tot++;
      if ({o_ca, o_cb} !== {ea, eb})
         $display("FAIL cmp_ops_hold: a=%h b=%h required %h %h", o_ca, o_cb, ea, eb);
      else n_pass++;

      if (stall > 0) begin
         bad_hold = 1'b0;
         for (int k = 0; k < int'(stall); k++) begin
            @(negedge clk);
            #1;
            if (o_rv !== 1'b1 || {o_id, o_leq, o_nan} !== {exp_id, exp_leq, exp_nan} ||
                o_en !== 1'b0 || o_r0 || o_r1 || o_ca !== ea || o_cb !== eb)
               bad_hold = 1'b1;
         end
         n_tot++;
         if (bad_hold) $display("FAIL rsp_hold: response changed or grant during %0d stall cycles", stall);
         else n_pass++;
      end
      rdy = 1'b1;
   endtask

   task automatic do_reset;
      @(negedge clk);
      rst = 1'b1; v0 = 1'b0; v1 = 1'b0; rdy = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      mptr[0] = 1'b0;
      mptr[1] = 1'b0;
   endtask

   task automatic test_reset;
      rst = 1'b1; v0 = 1'b1; v1 = 1'b1; rdy = 1'b1;
      for (int s = 0; s < 2; s++) begin
         @(negedge clk);
         sel = 1'(s);
         #1;
         n_tot++;
         if ({o_r1, o_r0} !== 2'b00) $display("FAIL ready_in_reset: %b%b required 00", o_r1, o_r0);
         else n_pass++;
         n_tot++;
         if ({o_en, o_rv, o_id, o_leq, o_nan} !== 5'b0)
            $display("FAIL reset_ctrl: en/rv/id/leq/nan=%b required 00000", {o_en, o_rv, o_id, o_leq, o_nan});
         else n_pass++;
         n_tot++;
         if ({o_ca, o_cb} !== 64'h0) $display("FAIL reset_ops: a=%h b=%h required 0", o_ca, o_cb);
         else n_pass++;
      end
      @(negedge clk);
      rst = 1'b0; v0 = 1'b0; v1 = 1'b0; rdy = 1'b0;
      mptr[0] = 1'b0;
      mptr[1] = 1'b0;
   endtask

   task automatic test_lat1;
      run_txn(1'b0, 1'b1, 1'b0, 32'h40200000, 32'h40200000, 32'h0, 32'h0, 0, 1'b0, 1'b0);
      run_txn(1'b0, 1'b0, 1'b1, 32'h0, 32'h0, 32'h41433333, 32'hC1600000, 0, 1'b0, 1'b0);
   endtask

   task automatic test_arbitration;
      do_reset();
      run_txn(1'b0, 1'b1, 1'b1, 32'hC3160000, 32'h43160000, 32'h42B40000, 32'h42F00000, 0, 1'b1, 1'b0);
      run_txn(1'b0, 1'b1, 1'b1, 32'hC3160000, 32'h43160000, 32'h42B40000, 32'h42F00000, 0, 1'b1, 1'b0);
      run_txn(1'b0, 1'b1, 1'b1, 32'hC3160000, 32'h43160000, 32'h42B40000, 32'h42F00000, 0, 1'b0, 1'b0);
   endtask

   task automatic test_stall;
      run_txn(1'b1, 1'b1, 1'b0, 32'h40200000, 32'h41433333, 32'h0, 32'h0, 4, 1'b0, 1'b0);
      run_txn(1'b1, 1'b1, 1'b1, 32'h41433333, 32'hC1600000, 32'hBF800000, 32'h3F800000, 4, 1'b1, 1'b0);
      run_txn(1'b1, 1'b1, 1'b1, 32'h3F800000, 32'h3F800000, 32'h00000000, 32'h80000000, 0, 1'b0, 1'b0);
   endtask

   task automatic test_valid_drop;
      run_txn(1'b1, 1'b1, 1'b0, 32'h42B40000, 32'h42F00000, 32'h0, 32'h0, 1, 1'b0, 1'b1);
      run_txn(1'b1, 1'b1, 1'b1, 32'h42F00000, 32'h42B40000, 32'hC3160000, 32'hC1600000, 0, 1'b0, 1'b0);
   endtask

   task automatic test_reset_midflight;
      logic bad;
      @(negedge clk);
      #1;
      sel = 1'b1; rdy = 1'b0;
      a0 = 32'h40200000; b0 = 32'h41433333; v0 = 1'b1; v1 = 1'b0;
      #1;
      n_tot++;
      if (o_r0 !== 1'b1) $display("FAIL mid_grant: req0_ready=%b required 1", o_r0);
      else n_pass++;
      @(negedge clk);
      v0 = 1'b0;
      @(negedge clk);
      rst = 1'b1; v0 = 1'b1;
      @(negedge clk);
      #1;
      n_tot++;
      if ({o_r1, o_r0} !== 2'b00) $display("FAIL ready_in_rst: %b%b required 00", o_r1, o_r0);
      else n_pass++;
      rst = 1'b0; v0 = 1'b0;
      mptr[0] = 1'b0;
      mptr[1] = 1'b0;
      n_tot++;
      if ({o_en, o_rv, o_id, o_leq, o_nan} !== 5'b0 || {o_ca, o_cb} !== 64'h0)
         $display("FAIL midrst_outputs: en/rv/id/leq/nan=%b a=%h b=%h required 0",
                  {o_en, o_rv, o_id, o_leq, o_nan}, o_ca, o_cb);
      else n_pass++;
      bad = 1'b0;
      repeat (LAT + 3) begin
         @(negedge clk);
         #1;
         if (o_rv || o_en) bad = 1'b1;
      end
      n_tot++;
      if (bad) $display("FAIL midrst_no_rsp: response or cmp_en after reset, required none");
      else n_pass++;
      run_txn(1'b1, 1'b1, 1'b0, 32'hC1600000, 32'h41433333, 32'h0, 32'h0, 0, 1'b0, 1'b0);
   endtask

   task automatic test_nan;
      run_txn(1'b1, 1'b1, 1'b0, 32'h7FC00000, 32'h3F800000, 32'h0, 32'h0, 2, 1'b0, 1'b0);
      run_txn(1'b0, 1'b0, 1'b1, 32'h0, 32'h0, 32'h3F800000, 32'h7F800001, 0, 1'b0, 1'b0);
      run_txn(1'b0, 1'b1, 1'b0, 32'h7F800000, 32'h7F800000, 32'h0, 32'h0, 0, 1'b0, 1'b0);
   endtask

   function automatic logic [31:0] rnd_fp();
      case ($urandom_range(0, 7))
         0:       return 32'h7FC00000 | 32'($urandom_range(0, 255));
         1:       return {1'($urandom), 31'h0};
         2:       return {1'($urandom), 8'hFF, 23'h0};
         default: return {1'($urandom), 8'($urandom_range(120, 135)), 23'($urandom)};
      endcase
   endfunction

   task automatic test_random;
      for (int i = 0; i < 40; i++) begin
         logic [1:0]  v;
         logic [31:0] x0, y0, x1, y1;
         logic        kl, gl;
         v  = 2'($urandom_range(1, 3));
         x0 = rnd_fp();
         y0 = ($urandom_range(0, 3) == 0) ? x0 : rnd_fp();
         x1 = rnd_fp();
         y1 = ($urandom_range(0, 3) == 0) ? x1 : rnd_fp();
         kl = 1'($urandom_range(0, 1));
         gl = !kl && ($urandom_range(0, 3) == 0);
         run_txn(1'($urandom_range(0, 1)), v[0], v[1], x0, y0, x1, y1,
                 $urandom_range(0, 3), kl, gl);
      end
   endtask

   initial begin
      n_pass = 0; n_tot = 0;
      sel = 1'b0; rdy = 1'b0; v0 = 1'b0; v1 = 1'b0;
      a0 = '0; b0 = '0; a1 = '0; b1 = '0;
      rst = 1'b1;
      mptr[0] = 1'b0;
      mptr[1] = 1'b0;
      test_reset();
      test_lat1();
      test_arbitration();
      test_stall();
      test_valid_drop();
      test_reset_midflight();
      test_nan();
      test_random();
      @(negedge clk);
      #1;
      n_tot++;
      if (o_rv !== 1'b0) $display("FAIL final_release: rsp_valid=%b required 0", o_rv);
      else n_pass++;
      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end
endmodule

// File: doc/fcmp_sched.md
FCMP_SCHED -- requirements
Module: fcmp_sched

Interface
REQ-001 Parameter CMP_LAT, default 1, comparator settle cycles with cmp_en high before capture; legal range 1..15.
REQ-002 clk  input  1  single rising-edge clock for all state.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 req0_valid / req1_valid  input  1 each  requester holds a compare request.
REQ-005 req0_a, req0_b / req1_a, req1_b  input  32 each  IEEE-754 single operands; the request is "a <= b".
REQ-006 req0_ready / req1_ready  output  1 each  request accepted this cycle.
REQ-007 cmp_en  output  1  enable to the shared Fleq comparator.
REQ-008 cmp_a, cmp_b  output  32 each  operands driven to the comparator read_data1 and read_data2.
REQ-009 cmp_result  input  32  comparator leqdata_out; any nonzero value means a <= b.
REQ-010 rsp_valid  output  1  result available.
REQ-011 rsp_id  output  1  requester index of the result.
REQ-012 rsp_leq  output  1  compare result.
REQ-013 rsp_nan  output  1  unordered operand flag; see Configuration.
REQ-014 rsp_ready  input  1  consumer accepts the result.

Function
REQ-015 The FSM SHALL have three states: IDLE, ISSUE and RESP; state SHALL change only on a clk rise.
REQ-016 In IDLE, if any valid is high, the block SHALL grant one requester and assert only that requester's ready, combinationally, in the same cycle.
REQ-017 On a grant, the FSM SHALL latch the granted a/b, latch rsp_id, clear the latency counter and go to ISSUE.
REQ-018 Arbitration SHALL be round-robin with a 1-bit pointer: if both valids are high, the pointer's requester wins; after every grant the pointer moves to the other requester; a lone valid always wins.
REQ-019 Outside IDLE both ready outputs SHALL be 0; a requester SHALL hold valid and its operands until ready.
REQ-020 In ISSUE, cmp_en SHALL be 1 and cmp_a/cmp_b SHALL carry the latched operands.
REQ-021 In ISSUE, the counter SHALL increment every cycle. On the cycle where counter == CMP_LAT-1, the block SHALL register rsp_leq = |cmp_result and go to RESP.
REQ-022 In IDLE and RESP, cmp_en SHALL be 0 and cmp_a/cmp_b SHALL hold their last values.
REQ-023 In RESP, rsp_valid SHALL be 1, with rsp_id, rsp_leq and rsp_nan stable, until a cycle with rsp_ready = 1; that cycle SHALL return the FSM to IDLE.
REQ-024 Latency SHALL be fixed: grant in cycle T means rsp_valid first rises in cycle T+CMP_LAT+1. The next grant SHALL come no earlier than the cycle after the rsp handshake.
REQ-025 A valid that drops before its grant SHALL be ignored, and the pointer SHALL stay unchanged.
REQ-026 rsp_ready high in IDLE or ISSUE SHALL have no effect.

Reset
REQ-027 With rst high at a clk rise, the block SHALL set: state = IDLE, pointer = req0, counter = 0, cmp_en = 0, cmp_a = cmp_b = 0, rsp_valid = 0, rsp_id = 0, rsp_leq = 0, rsp_nan = 0.
REQ-028 Reset during ISSUE or RESP SHALL drop the in-flight request with no response; ready SHALL be 0 while rst is high.

Configuration
REQ-029 With macro FCMP_NAN_CHECK_EN defined, the block SHALL check each operand at grant (exponent 8'hFF and mantissa nonzero); on a NaN it SHALL skip ISSUE, go directly to RESP next cycle, and set rsp_leq = 0 and rsp_nan = 1.
REQ-030 Without FCMP_NAN_CHECK_EN, rsp_nan SHALL be tied 0, and every request SHALL pass through ISSUE.

Verification
REQ-031 CMP_LAT = 1, req0 2.5 <= 2.5 (0x40200000, 0x40200000), rsp_ready = 1 -> rsp_valid at T+2, rsp_id = 0, rsp_leq = 1, cmp_en high exactly 1 cycle.
REQ-032 req1 12.2 vs -14 (0x41433333, 0xC1600000) -> rsp_id = 1, rsp_leq = 0.
REQ-033 Both valid from reset, req0 -150 vs 150 and req1 90 vs 120 -> req0 granted first (leq 1), then req1 (leq 1); a third simultaneous pair grants req0 again.
REQ-034 CMP_LAT = 3, rsp_ready low 4 cycles -> cmp_en high 3 cycles; rsp_valid and fields held steady; no new grant until the handshake.
REQ-035 rst pulse in cycle 2 of ISSUE (CMP_LAT = 3) -> no rsp_valid; all outputs at reset values; a later req0 is serviced normally.
REQ-036 FCMP_NAN_CHECK_EN defined, a = 0x7FC00000 -> no cmp_en, rsp_valid at T+1, rsp_nan = 1, rsp_leq = 0; without the macro, the same stimulus takes the normal ISSUE path.
